// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with a retired-instruction counter.
// Optional macro BRANCH_UNSIGNED_EN enables unsigned branches (funct3 110/111).
module multicycle_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 notZero,
  input  logic                 LessThan,
  input  logic                 GreaterEqual,
  input  logic                 LessThanU,
  input  logic                 GreaterEqualU,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [CNT_W-1:0]     InstRet,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;
  logic   cond_branch, branch_legal, illegal_dec, retire;
  logic   pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic [2:0] alu_op, alu_fn;

`ifndef BRANCH_UNSIGNED_EN
  logic unused_flags;
  assign unused_flags = &{1'b0, LessThanU, GreaterEqualU};
`endif

  // Branch condition and legality, both decoded from funct3 alone.
  always_comb begin
    cond_branch  = 1'b0;
    branch_legal = 1'b1;
    case (funct3)
      3'b000: cond_branch = Zero;
      3'b001: cond_branch = notZero;
      3'b100: cond_branch = LessThan;
      3'b101: cond_branch = GreaterEqual;
`ifdef BRANCH_UNSIGNED_EN
      3'b110: cond_branch = LessThanU;
      3'b111: cond_branch = GreaterEqualU;
`endif
      default: branch_legal = 1'b0;
    endcase
  end

  always_comb begin
    illegal_dec = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL: illegal_dec = 1'b0;
      OP_BR:   illegal_dec = !branch_legal;
      default: illegal_dec = 1'b1;
    endcase
  end

  // Subtract only for R-type funct3=000 with funct7b5 set; I-type 000 is always add.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_BR:             state_d = branch_legal ? S_BRANCH : S_FETCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = alu_fn;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = alu_fn;
      end
      S_ALUWB:    reg_write_raw = 1'b1;
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        alu_op       = ALU_SUB;
        pc_write_raw = cond_branch;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BR:    ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Enables are qualified by reset so nothing writes while reset is held.
  assign PCWrite    = reset & pc_write_raw;
  assign IRWrite    = reset & ir_write_raw;
  assign MemWrite   = reset & mem_write_raw;
  assign RegWrite   = reset & reg_write_raw;
  assign Illegal    = reset & (state_q == S_DECODE) & illegal_dec;
  assign ALUControl = ALUCTRL_W'(alu_op);
  assign state      = state_q;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                  (state_q == S_BRANCH) || ((state_q == S_MEMWRITE) && MemReady);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      InstRet <= '0;
    else if (retire) InstRet <= InstRet + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (CNT_W=4 to exercise counter wrap).
module tb_multicycle_controller;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, notZero, LessThan, GreaterEqual, LessThanU, GreaterEqualU, MemReady;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  logic [3:0] InstRet;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  multicycle_controller #(.ALUCTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .notZero(notZero), .LessThan(LessThan), .GreaterEqual(GreaterEqual),
    .LessThanU(LessThanU), .GreaterEqualU(GreaterEqualU), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .InstRet(InstRet),
    .state(state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [5:0] f);
    {Zero, notZero, LessThan, GreaterEqual, LessThanU, GreaterEqualU} = f;
  endtask

  // Starts in FETCH; walks an R/I instruction through execute and writeback.
  task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [3:0] exp_alu, input logic [3:0] exp_st,
                         input logic [1:0] exp_srcb);
    op = o; funct3 = f3; funct7b5 = f7; #1;
    tick();
    check("alu_dec_st", state, 1);
    tick();
    check("alu_ex_st", state, exp_st);
    check("alu_ctrl", ALUControl, exp_alu);
    check("alu_srcb", ALUSrcB, exp_srcb);
    tick();
    check("alu_wb_st", state, 8);
    check("alu_wb_rw", RegWrite, 1);
    tick();
    exp_cnt++;
    check("alu_done_st", state, 0);
    check("alu_cnt", InstRet, exp_cnt % 16);
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic [5:0] f,
                            input logic exp_pcw, input logic legal);
    op = OP_BR; funct3 = f3; set_flags(f); #1;
    tick();
    check("br_dec_ill", Illegal, !legal);
    check("br_dec_imm", ImmSrc, 2);
    tick();
    if (legal) begin
      check("br_st", state, 9);
      check("br_pcw", PCWrite, exp_pcw);
      check("br_alu", ALUControl, 1);
      tick();
      exp_cnt++;
    end
    check("br_done_st", state, 0);
    check("br_cnt", InstRet, exp_cnt % 16);
    set_flags(6'b0);
  endtask

  initial begin
    reset = 1'b0; op = OP_LOAD; funct3 = 3'b000; funct7b5 = 1'b0;
    set_flags(6'b0); MemReady = 1'b1;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_cnt", InstRet, 0);
    check("rst_pcw", PCWrite, 0);
    check("rst_irw", IRWrite, 0);
    check("rst_ill", Illegal, 0);
    reset = 1'b1;

    // FETCH holds without MemReady
    MemReady = 1'b0; #1;
    check("fetch_hold_irw", IRWrite, 0);
    check("fetch_hold_pcw", PCWrite, 0);
    tick();
    check("fetch_hold_st", state, 0);
    MemReady = 1'b1; #1;

    // lw: F, D, MA, MR, WB
    check("lw_f_irw", IRWrite, 1);
    check("lw_f_pcw", PCWrite, 1);
    check("lw_f_srcb", ALUSrcB, 2);
    check("lw_f_res", ResultSrc, 2);
    tick();
    check("lw_d_st", state, 1);
    check("lw_d_srca", ALUSrcA, 1);
    check("lw_d_srcb", ALUSrcB, 1);
    tick();
    check("lw_ma_st", state, 2);
    check("lw_ma_srca", ALUSrcA, 2);
    tick();
    check("lw_mr_st", state, 3);
    check("lw_mr_adr", AdrSrc, 1);
    check("lw_mr_rw", RegWrite, 0);
    tick();
    check("lw_wb_st", state, 4);
    check("lw_wb_rw", RegWrite, 1);
    check("lw_wb_res", ResultSrc, 1);
    tick();
    exp_cnt++;
    check("lw_done_st", state, 0);
    check("lw_cnt", InstRet, exp_cnt % 16);

    // sw with three wait cycles in MEMWRITE
    op = OP_STORE; #1;
    check("sw_f_mw", MemWrite, 0);
    tick();
    check("sw_d_imm", ImmSrc, 1);
    tick();
    check("sw_ma_st", state, 2);
    tick();
    MemReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("sw_wait_st", state, 5);
      check("sw_wait_mw", MemWrite, 1);
      check("sw_wait_cnt", InstRet, exp_cnt % 16);
      tick();
    end
    MemReady = 1'b1; #1;
    check("sw_last_mw", MemWrite, 1);
    check("sw_last_adr", AdrSrc, 1);
    tick();
    exp_cnt++;
    check("sw_done_st", state, 0);
    check("sw_cnt", InstRet, exp_cnt % 16);

    // ALU decode table
    run_alu(OP_R, 3'b000, 1'b1, 4'd1, 4'd6, 2'b00);
    run_alu(OP_R, 3'b000, 1'b0, 4'd0, 4'd6, 2'b00);
    run_alu(OP_R, 3'b110, 1'b0, 4'd3, 4'd6, 2'b00);
    run_alu(OP_I, 3'b111, 1'b0, 4'd2, 4'd7, 2'b01);
    run_alu(OP_I, 3'b010, 1'b0, 4'd5, 4'd7, 2'b01);
    run_alu(OP_I, 3'b000, 1'b1, 4'd0, 4'd7, 2'b01);

    // jal: F, D, JAL, ALUWB
    op = OP_JAL; #1;
    tick();
    check("jal_d_imm", ImmSrc, 3);
    tick();
    check("jal_st", state, 10);
    check("jal_pcw", PCWrite, 1);
    check("jal_srca", ALUSrcA, 1);
    check("jal_srcb", ALUSrcB, 2);
    tick();
    check("jal_wb_st", state, 8);
    tick();
    exp_cnt++;
    check("jal_cnt", InstRet, exp_cnt % 16);

    // Branches: flags order {Zero,notZero,LT,GE,LTU,GEU}
    run_branch(3'b000, 6'b100000, 1'b1, 1'b1);
    run_branch(3'b001, 6'b000000, 1'b0, 1'b1);
    run_branch(3'b100, 6'b001000, 1'b1, 1'b1);
    run_branch(3'b101, 6'b111011, 1'b0, 1'b1);
    run_branch(3'b010, 6'b111111, 1'b0, 1'b0);
`ifdef BRANCH_UNSIGNED_EN
    run_branch(3'b110, 6'b000010, 1'b1, 1'b1);
    run_branch(3'b111, 6'b111110, 1'b0, 1'b1);
`else
    run_branch(3'b110, 6'b000010, 1'b0, 1'b0);
    run_branch(3'b111, 6'b000001, 1'b0, 1'b0);
`endif

    // Unsupported opcode
    op = 7'b1111111; #1;
    tick();
    check("ill_dec_st", state, 1);
    check("ill_pulse", Illegal, 1);
    check("ill_pcw", PCWrite, 0);
    tick();
    check("ill_done_st", state, 0);
    check("ill_after", Illegal, 0);
    check("ill_cnt", InstRet, exp_cnt % 16);

    // Reset asserted in MEMREAD
    op = OP_LOAD; #1;
    tick(); tick(); tick();
    check("rmr_st", state, 3);
    reset = 1'b0; #1;
    exp_cnt = 0;
    check("rmr_rst_st", state, 0);
    check("rmr_rst_cnt", InstRet, 0);
    check("rmr_rst_rw", RegWrite, 0);
    check("rmr_rst_pcw", PCWrite, 0);
    tick();
    check("rmr_hold_cnt", InstRet, 0);
    reset = 1'b1; #1;

    // Counter wrap at CNT_W=4
    for (int i = 0; i < 15; i++) run_branch(3'b001, 6'b000000, 1'b0, 1'b1);
    check("wrap_15", InstRet, 15);
    run_branch(3'b001, 6'b000000, 1'b0, 1'b1);
    check("wrap_zero", InstRet, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width, legal range 3..4, upper bits above bit 2 driven 0.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 op  in  7; funct3  in  3; funct7b5  in  1  instruction fields taken from the instruction register.
REQ-006 Zero, notZero, LessThan, GreaterEqual, LessThanU, GreaterEqualU  in  1 each  ALU compare flags.
REQ-007 MemReady  in  1  memory handshake; 1 = the current access completes this cycle.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath selects.
REQ-010 ALUControl  out  ALUCTRL_W  ALU operation code.
REQ-011 Illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or branch funct3.
REQ-012 InstRet  out  CNT_W  count of completed instructions.

Function
REQ-013 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALU add; IRWrite=PCWrite=MemReady; advance to DECODE only when MemReady=1, otherwise hold.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ALU add; next state by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, other->FETCH with Illegal=1.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, add; op[5]=0->MEMREAD, 1->MEMWRITE.
REQ-017 MEMREAD: ResultSrc=00, AdrSrc=1; hold until MemReady, then MEMWB.
REQ-018 MEMWRITE: AdrSrc=1, MemWrite=1; hold until MemReady, then FETCH.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-020 EXECUTER/EXECUTEI: ALUSrcA=10, ALUSrcB=00 (R) / 01 (I), funct3-decoded op, then ALUWB; ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=CondBranch, then FETCH.
REQ-023 CondBranch by funct3: 000 Zero, 001 notZero, 100 LessThan, 101 GreaterEqual, 110 LessThanU, 111 GreaterEqualU (the last two only per REQ-031); other values give CondBranch=0 and Illegal=1 in DECODE.
REQ-024 ALUControl: add=000, sub=001, and=010, or=011, slt=101; funct3 000 selects sub only when op[5]=1 and funct7b5=1; other funct3 values select add.
REQ-025 ImmSrc by op: I/load 00, store 01, branch 10, jal 11.
REQ-026 All outputs except InstRet are combinational from state and inputs (Moore plus MemReady/CondBranch gating); any enable not listed for a state is 0.
REQ-027 InstRet increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, wraps modulo 2^CNT_W, and does not count illegal aborts.
REQ-028 Latency with MemReady held at 1: lw 5 cycles, sw/R/I/jal 4, branch 3.

Reset
REQ-029 reset=0 forces state=FETCH and InstRet=0 asynchronously; while reset=0, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are 0.
REQ-030 Reset asserted mid-instruction discards the instruction, with no count and no write enable after assertion.

Configuration
REQ-031 With macro BRANCH_UNSIGNED_EN defined, funct3 110/111 are legal branches; without it they are illegal (Illegal=1, return to FETCH, no PC write), and LessThanU/GreaterEqualU are ignored.

Verification
REQ-032 Reset, then lw (op=0000011) with MemReady=1 -> states F,D,MA,MR,WB; RegWrite=1 in cycle 5; InstRet=1.
REQ-033 sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite held at 1 for 4 cycles; FETCH after MemReady=1; InstRet +1.
REQ-034 beq with Zero=1 -> PCWrite=1 in BRANCH; bne with notZero=0 -> PCWrite=0; each completes in 3 cycles.
REQ-035 op=1111111 -> Illegal=1 in DECODE, FETCH next cycle, InstRet unchanged.
REQ-036 funct3=110 with LessThanU=1 -> PCWrite=1 when the macro is defined; Illegal=1 and no PC write when it is not.
REQ-037 reset=0 asserted in MEMREAD -> immediate FETCH and InstRet=0; CNT_W=4 after 16 instructions -> InstRet=0.
